kb_dev: RTL and testbench

KB_DEV -- requirements
Module: kb_dev

---
 rtl/kb_dev.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_kb_dev.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_dev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : kb_dev                                                           |
// | Purpose : PS/2 keyboard-side device. Sends queued scan codes to the host   |
// |           and receives host command bytes. The device generates the PS/2   |
// |           clock and acknowledges each good host frame.                     |
// | Ports   : clock, reset        - system clock / async active-high reset     |
// |           ps_clk, ps_dat      - open-drain PS/2 lines (drive 0 or z)       |
// |           tx_valid, tx_data   - push a byte into the 4-entry transmit FIFO |
// |           tx_ready            - FIFO not full                              |
// |           rx_data             - last good byte received from the host      |
// |           rx_valid, rx_err    - one-cycle result pulses for host frames    |
// |           busy                - line state machine not idle                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module kb_dev #(
  parameter int HALF = 1000,
  parameter int GAP  = 1250
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        ps_clk,
  inout  wire        ps_dat,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int            TW          = $clog2(((HALF > GAP) ? HALF : GAP) + 1);
  localparam logic [TW-1:0] C_HALF_LAST = TW'(HALF - 1);
  localparam logic [TW-1:0] C_GAP_LAST  = TW'(GAP - 1);
  localparam logic [3:0]    C_LAST_CELL = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_RX      = 3'd2,
    S_ACK     = 3'd3,
    S_INHIBIT = 3'd4,
    S_WAITGAP = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          phase_q, phase_d;     // 0: phase A (clock released), 1: phase B (clock low)
  logic [3:0]    cell_q, cell_d;
  logic          clk_oe_q, clk_oe_d;   // 1 pulls ps_clk low
  logic          dat_oe_q, dat_oe_d;   // 1 pulls ps_dat low
  logic [8:0]    rx_sh_q, rx_sh_d;     // {parity, data[7:0]} once the frame is in
  logic          stop_q, stop_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic [7:0]    mem_q [4];
  logic [7:0]    mem_d [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          psc_meta_q, psc_sync_q;
  logic          psd_meta_q, psd_sync_q;

  logic          w_full, w_empty, w_push, w_pop, w_timer_last;
  logic [7:0]    w_head;

  // Open-drain outputs straight from flops so reset releases the lines at once.
  assign ps_clk   = clk_oe_q ? 1'b0 : 1'bz;
  assign ps_dat   = dat_oe_q ? 1'b0 : 1'bz;

  assign tx_ready = ~w_full;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = (state_q != S_IDLE);

  assign w_full       = (count_q == 3'd4);
  assign w_empty      = (count_q == 3'd0);
  assign w_head       = mem_q[rd_ptr_q];
  assign w_timer_last = (timer_q == C_HALF_LAST);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept then.
  assign w_push       = tx_valid & (~w_full | w_pop);

  // Line level for a transmit cell: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic tx_bit(input logic [3:0] c, input logic [7:0] b);
    case (c)
      4'd0:    tx_bit = 1'b0;
      4'd9:    tx_bit = ~^b;
      4'd10:   tx_bit = 1'b1;
      default: tx_bit = b[3'(c - 4'd1)];
    endcase
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    phase_d    = phase_q;
    cell_d     = cell_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    rx_sh_d    = rx_sh_q;
    stop_d     = stop_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    w_pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        phase_d  = 1'b0;
        cell_d   = 4'd0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (!psc_sync_q) begin
          state_d = S_INHIBIT;
        end else if (!psd_sync_q) begin
          state_d = S_RX;
        end else if (!w_empty) begin
          state_d  = S_TX;
          dat_oe_d = ~tx_bit(4'd0, w_head);
        end
      end

      S_TX: begin
        timer_d = timer_q + TW'(1);
        if (w_timer_last) begin
          timer_d = '0;
          if (!phase_q) begin
            if (!psc_sync_q) begin
              // Host inhibit: the byte is only consumed if the stop cell was reached.
              w_pop    = (cell_q == C_LAST_CELL);
              state_d  = S_INHIBIT;
              dat_oe_d = 1'b0;
            end else begin
              phase_d  = 1'b1;
              clk_oe_d = 1'b1;
            end
          end else begin
            phase_d  = 1'b0;
            clk_oe_d = 1'b0;
            if (cell_q == C_LAST_CELL) begin
              w_pop    = 1'b1;
              state_d  = S_WAITGAP;
              dat_oe_d = 1'b0;
            end else begin
              cell_d   = cell_q + 4'd1;
              dat_oe_d = ~tx_bit(cell_q + 4'd1, w_head);
            end
          end
        end
      end

      S_RX: begin
        timer_d = timer_q + TW'(1);
        if (w_timer_last) begin
          timer_d = '0;
          if (!phase_q) begin
            if (!psc_sync_q) begin
              rx_err_d = 1'b1;
              state_d  = S_INHIBIT;
            end else if ((cell_q == 4'd0) && psd_sync_q) begin
              // Start bit was not held low: not a valid request.
              rx_err_d = 1'b1;
              state_d  = S_WAITGAP;
            end else begin
              phase_d  = 1'b1;
              clk_oe_d = 1'b1;
              if (cell_q == C_LAST_CELL) begin
                stop_d = psd_sync_q;
              end else if (cell_q != 4'd0) begin
                rx_sh_d = {psd_sync_q, rx_sh_q[8:1]};
              end
            end
          end else begin
            phase_d  = 1'b0;
            clk_oe_d = 1'b0;
            if (cell_q == C_LAST_CELL) begin
              if (stop_q) begin
                state_d  = S_ACK;
                dat_oe_d = 1'b1;
              end else begin
                rx_err_d = 1'b1;
                state_d  = S_WAITGAP;
              end
            end else begin
              cell_d = cell_q + 4'd1;
            end
          end
        end
      end

      S_ACK: begin
        timer_d = timer_q + TW'(1);
        if (w_timer_last) begin
          timer_d = '0;
          if (!phase_q) begin
            phase_d  = 1'b1;
            clk_oe_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_WAITGAP;
            if (^rx_sh_q) begin
              rx_data_d  = rx_sh_q[7:0];
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
          end
        end
      end

      S_INHIBIT: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        phase_d  = 1'b0;
        // The gap only counts while the host keeps the clock released.
        if (!psc_sync_q) begin
          timer_d = '0;
        end else if (timer_q == C_GAP_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAITGAP: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        phase_d  = 1'b0;
        if (timer_q == C_GAP_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        timer_d  = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      phase_q    <= 1'b0;
      cell_q     <= 4'd0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      rx_sh_q    <= 9'd0;
      stop_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      // Synchronizers come up at the idle (released) line level.
      psc_meta_q <= 1'b1;
      psc_sync_q <= 1'b1;
      psd_meta_q <= 1'b1;
      psd_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      cell_q     <= cell_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      rx_sh_q    <= rx_sh_d;
      stop_q     <= stop_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      psc_meta_q <= ps_clk;
      psc_sync_q <= psc_meta_q;
      psd_meta_q <= ps_dat;
      psd_sync_q <= psd_meta_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kb_dev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_kb_dev                                                        |
// | Purpose : Directed self-checking bench for kb_dev. Models a PS/2 host on   |
// |           pulled-up open-drain lines and checks frames, FIFO behaviour,    |
// |           host receive/ack, inhibit recovery and asynchronous reset.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_kb_dev;

  localparam int HALF   = 8;
  localparam int GAP    = 20;
  localparam int BUDGET = 4 * HALF + 2 * GAP;

  logic       clock        = 1'b0;
  logic       reset        = 1'b1;
  logic       tx_valid     = 1'b0;
  logic [7:0] tx_data      = 8'h00;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;
  logic       tx_ready, rx_valid, rx_err, busy;
  logic [7:0] rx_data;
  wire        ps_clk;
  wire        ps_dat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  assign ps_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps_dat = host_dat_low ? 1'b0 : 1'bz;
  pullup (ps_clk);
  pullup (ps_dat);

  kb_dev #(.HALF(HALF), .GAP(GAP)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps_clk   (ps_clk),
    .ps_dat   (ps_dat),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the byte for exactly one rising edge.
  task automatic push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // Waits for a 1->0 transition of ps_clk, sampled on the falling system clock.
  task automatic wait_fall(input int budget, output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = ps_clk;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (prev === 1'b1 && ps_clk === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = ps_clk;
    end
  endtask

  // Host view of a device frame: ps_dat sampled at each ps_clk fall, bit 0 = start.
  task automatic collect_frame(output logic [10:0] bits, output int bad_gap, output int t_first);
    bit f;
    int last;
    bits    = '0;
    bad_gap = 0;
    t_first = 0;
    last    = 0;
    for (int k = 0; k < 11; k++) begin
      wait_fall(BUDGET, f);
      if (!f) begin
        bad_gap++;
        break;
      end
      bits[k] = ps_dat;
      if (k == 0) t_first = cyc;
      else if ((cyc - last) != 2 * HALF) bad_gap++;
      last = cyc;
    end
  endtask

  // Host-to-device frame: data changes right after each clock fall.
  task automatic host_send(input logic [7:0] b, input logic par, input logic stp, output int nfalls);
    logic [10:0] bits;
    bit f;
    bits         = {stp, par, b, 1'b0};
    nfalls       = 0;
    host_dat_low = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wait_fall(BUDGET, f);
      if (!f) break;
      nfalls++;
      host_dat_low = (k < 10) ? ~bits[k + 1] : 1'b0;
    end
    host_dat_low = 1'b0;
  endtask

  task automatic watch(input int n, output int nv, output int ne, output int nboth, output int dlow);
    nv = 0; ne = 0; nboth = 0; dlow = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (rx_valid === 1'b1) nv++;
      if (rx_err === 1'b1) ne++;
      if (rx_valid === 1'b1 && rx_err === 1'b1) nboth++;
      if (ps_dat === 1'b0) dlow++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < BUDGET * 4) begin
      @(negedge clock);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    logic [10:0] fr;
    logic [10:0] exp_fr [4];
    int bad, t0, t1, n, nv, ne, nb, dl;
    bit f;

    // Odd parity: F0/AA/55 have four ones -> parity 1; 1C has three -> parity 0.
    exp_fr[0] = {1'b1, 1'b1, 8'hF0, 1'b0};
    exp_fr[1] = {1'b1, 1'b0, 8'h1C, 1'b0};
    exp_fr[2] = {1'b1, 1'b1, 8'hAA, 1'b0};
    exp_fr[3] = {1'b1, 1'b1, 8'h55, 1'b0};

    // ---- reset state ----
    repeat (3) @(negedge clock);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_err", rx_err, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_ps_clk", ps_clk, 1'b1);
    chk("rst_ps_dat", ps_dat, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // ---- single byte 1C, host passive ----
    push(8'h1C);
    chk("tx1_ready", tx_ready, 1'b1);
    collect_frame(fr, bad, t0);
    chk("tx1_frame", fr, 11'b1_0_00011100_0);
    chk("tx1_gaps", bad, 0);
    chk("tx1_ready_after", tx_ready, 1'b1);
    n = 0;
    for (int i = 0; i < HALF + GAP + 20; i++) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      n++;
    end
    chk("tx1_busy_tail", n, HALF + GAP - 1);

    // ---- FIFO fill: 4 accepted, 5th dropped ----
    push(8'hF0);
    push(8'h1C);
    push(8'hAA);
    chk("fifo_ready_3", tx_ready, 1'b1);
    push(8'h55);
    chk("fifo_ready_4", tx_ready, 1'b0);
    push(8'hEE);
    for (int j = 0; j < 4; j++) begin
      collect_frame(fr, bad, t0);
      chk($sformatf("fifo_frame%0d", j), fr, exp_fr[j]);
      chk($sformatf("fifo_gaps%0d", j), bad, 0);
    end
    wait_fall(BUDGET, f);
    chk("fifo_no_fifth", f, 1'b0);
    chk("fifo_ready_end", tx_ready, 1'b1);
    wait_idle("fifo_idle");

    // ---- host sends ED with correct odd parity (six ones -> parity 1) ----
    host_send(8'hED, 1'b1, 1'b1, n);
    chk("rx1_falls", n, 11);
    watch(3 * HALF + GAP + 8, nv, ne, nb, dl);
    chk("rx1_valid_cnt", nv, 1);
    chk("rx1_err_cnt", ne, 0);
    chk("rx1_ack_low", dl, 2 * HALF);
    chk("rx1_data", rx_data, 8'hED);
    chk("rx1_idle", busy, 1'b0);

    // ---- host sends 5A with wrong parity: ACK still driven, error pulse ----
    host_send(8'h5A, 1'b0, 1'b1, n);
    chk("rx2_falls", n, 11);
    watch(3 * HALF + GAP + 8, nv, ne, nb, dl);
    chk("rx2_valid_cnt", nv, 0);
    chk("rx2_err_cnt", ne, 1);
    chk("rx2_ack_low", dl, 2 * HALF);
    chk("rx2_data_kept", rx_data, 8'hED);
    chk("rx2_both", nb, 0);

    // ---- host sends 01 with stop bit 0: no ACK, error pulse ----
    host_send(8'h01, 1'b0, 1'b0, n);
    chk("rx3_falls", n, 11);
    watch(3 * HALF + GAP + 8, nv, ne, nb, dl);
    chk("rx3_valid_cnt", nv, 0);
    chk("rx3_err_cnt", ne, 1);
    chk("rx3_no_ack", dl, 0);
    chk("rx3_data_kept", rx_data, 8'hED);
    wait_idle("rx3_idle");

    // ---- host inhibit during cell 5 of 1C, then full resend ----
    push(8'h1C);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      wait_fall(BUDGET, f);
      if (f) n++;
    end
    chk("inh_first_falls", n, 5);
    repeat (HALF + 2) @(negedge clock);
    host_clk_low = 1'b1;
    repeat (3 * HALF) @(negedge clock);
    chk("inh_busy", busy, 1'b1);
    host_clk_low = 1'b0;
    t1 = cyc;
    #1;
    chk("inh_clk_released", ps_clk, 1'b1);
    chk("inh_dat_released", ps_dat, 1'b1);
    @(negedge clock);
    collect_frame(fr, bad, t0);
    chk("inh_resend_frame", fr, 11'b1_0_00011100_0);
    chk("inh_resend_gaps", bad, 0);
    chk("inh_wait_gap", (t0 - t1) >= (GAP + HALF), 1'b1);
    wait_idle("inh_idle");

    // ---- asynchronous reset during cell 3 with two bytes queued ----
    push(8'hA1);
    push(8'hB2);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      wait_fall(BUDGET, f);
      if (f) n++;
    end
    chk("arst_falls", n, 4);
    chk("arst_dat_low", ps_dat, 1'b0);   // A1 bit 2 is 0
    reset = 1'b1;
    #1;
    chk("arst_clk_z", ps_clk, 1'b1);
    chk("arst_dat_z", ps_dat, 1'b1);
    chk("arst_ready", tx_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    watch(BUDGET, nv, ne, nb, dl);
    chk("arst_no_pulse", nv + ne, 0);
    wait_fall(BUDGET, f);
    chk("arst_no_frame", f, 1'b0);
    chk("arst_busy_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
